// File: rtl/pqp_control_fsm_pkg.sv
// -----------------------------------------------------------------------------
// pqp_control_fsm_pkg
// Shared definitions for the PQP control unit.
//   - opcode map (instr[15:12])
//   - FSM state encodings (3-bit, exposed on o_State)
//   - ALU operation codes and PC source select codes
//   - ctrl_t: bundle of every datapath control line the FSM drives
//   - helpers that classify opcodes
// -----------------------------------------------------------------------------
package pqp_control_fsm_pkg;

  // Opcode map
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h6;
  localparam logic [3:0] OP_SW   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_HLT  = 4'hF;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_HALT   = 3'd6;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;

  // PC source select
  localparam logic [1:0] PC_INC    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // Every control line the FSM produces in one cycle.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_sel;
    logic [2:0] alu_op;
    logic       alu_src_b;
    logic       reg_write;
    logic       wb_sel;
    logic       retired;
    logic       illegal;
    logic       halted;
  } ctrl_t;

  // Opcodes that need an EXEC cycle (everything defined except NOP/HLT).
  function automatic logic needs_exec(input logic [3:0] op);
    needs_exec = (op >= OP_ADD) && (op <= OP_JMP);
  endfunction

  // ALU code for the register-register group; anything else adds.
  function automatic logic [2:0] rr_alu_op(input logic [3:0] op);
    case (op)
      OP_SUB:  rr_alu_op = ALU_SUB;
      OP_AND:  rr_alu_op = ALU_AND;
      OP_OR:   rr_alu_op = ALU_OR;
      default: rr_alu_op = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/pqp_wait_timer.sv
// -----------------------------------------------------------------------------
// pqp_wait_timer
// Memory wait-state watchdog. Counts cycles while i_En is high; i_Clr returns
// the count to zero. o_Expired is high in a cycle where the request is still
// waiting and TIMEOUT waiting cycles have already elapsed, i.e. on the
// (TIMEOUT+1)-th consecutive cycle without an acknowledge.
// Ports:
//   i_Clk      clock, rising edge
//   i_Rst      asynchronous active-high reset
//   i_En       count this cycle (request pending, no ack)
//   i_Clr      clear the count (ack seen or no request pending)
//   o_Expired  wait limit reached this cycle
// -----------------------------------------------------------------------------
module pqp_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_En,
  input  logic i_Clr,
  output logic o_Expired
);

  localparam int W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

  logic [W-1:0] r_cnt;

  // Saturates at LIMIT so the count can never wrap back under the limit.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_cnt <= '0;
    end else if (i_Clr) begin
      r_cnt <= '0;
    end else if (i_En && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_Expired = i_En && (r_cnt == LIMIT);

endmodule

// File: rtl/pqp_control_fsm.sv
// -----------------------------------------------------------------------------
// pqp_control_fsm
// Multi-cycle control unit for the PQP processor. Walks each instruction
// through FETCH / DECODE / EXEC / MEM / WB and drives the datapath enables and
// muxes; owns the memory req/ack handshake and its watchdog.
//
// Memory handshake: o_MemReq is held high for as long as the FSM sits in FETCH
// or MEM; the request completes in the cycle i_MemAck is high, and only in that
// cycle do the completion strobes (IrWrite/PcWrite in FETCH, the MEM exit)
// fire. If no ack has arrived after TIMEOUT+1 request cycles, o_Fault is set
// and the FSM parks in HALT; an ack in that same cycle still wins.
//
// Ports:
//   i_Clk, i_Rst        clock, asynchronous active-high reset
//   i_Opcode[3:0]       instruction opcode from the IR
//   i_Zero              ALU zero flag (EXEC)
//   i_MemAck            memory completes the current request
//   o_MemReq/o_MemWe    memory request / write
//   o_AddrSel           memory address: 0 = PC, 1 = ALU result register
//   o_IrWrite           load IR
//   o_PcWrite/o_PcSel   load PC / PC source
//   o_AluOp/o_AluSrcB   ALU function / operand B source
//   o_RegWrite/o_WbSel  register write / write-back source
//   o_Retired           instruction completed (1-cycle pulse)
//   o_InstrCount        retired-instruction count (wraps)
//   o_Illegal           undefined opcode seen in DECODE (1-cycle pulse)
//   o_Halted            in HALT
//   o_Fault             sticky memory-watchdog fault
//   o_State             current FSM state
// -----------------------------------------------------------------------------
module pqp_control_fsm
  import pqp_control_fsm_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic [3:0]       i_Opcode,
  input  logic             i_Zero,
  input  logic             i_MemAck,
  output logic             o_MemReq,
  output logic             o_MemWe,
  output logic             o_AddrSel,
  output logic             o_IrWrite,
  output logic             o_PcWrite,
  output logic [1:0]       o_PcSel,
  output logic [2:0]       o_AluOp,
  output logic             o_AluSrcB,
  output logic             o_RegWrite,
  output logic             o_WbSel,
  output logic             o_Retired,
  output logic [CNT_W-1:0] o_InstrCount,
  output logic             o_Illegal,
  output logic             o_Halted,
  output logic             o_Fault,
  output logic [2:0]       o_State
);

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  ctrl_t            w_ctrl;
  logic             w_set_fault;
  logic             w_wait_en;
  logic             w_expired;
  logic             r_fault;
  logic [CNT_W-1:0] r_count;

  // A request is waiting whenever we are in a memory state without an ack.
  // Any other situation (ack, or another state) clears the watchdog, so each
  // FETCH/MEM visit starts counting from zero.
  assign w_wait_en = ((r_state == ST_FETCH) || (r_state == ST_MEM)) && !i_MemAck;

  pqp_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .i_Clk     (i_Clk),
    .i_Rst     (i_Rst),
    .i_En      (w_wait_en),
    .i_Clr     (!w_wait_en),
    .o_Expired (w_expired)
  );

  // State register; reset drops to IDLE asynchronously, which also forces
  // every state-derived output (including a pending MemReq) low at once.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and control decode.
  always_comb begin
    w_next      = r_state;
    w_ctrl      = '0;
    w_set_fault = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_next = ST_FETCH;
      end

      ST_FETCH: begin
        w_ctrl.mem_req  = 1'b1;
        w_ctrl.addr_sel = 1'b0;
        if (i_MemAck) begin
          w_ctrl.ir_write = 1'b1;
          w_ctrl.pc_write = 1'b1;
          w_ctrl.pc_sel   = PC_INC;
          w_next          = ST_DECODE;
        end else if (w_expired) begin
          w_set_fault = 1'b1;
          w_next      = ST_HALT;
        end
      end

      ST_DECODE: begin
        if (i_Opcode == OP_NOP) begin
          w_ctrl.retired = 1'b1;
          w_next         = ST_FETCH;
        end else if (i_Opcode == OP_HLT) begin
          w_ctrl.retired = 1'b1;
          w_next         = ST_HALT;
        end else if (needs_exec(i_Opcode)) begin
          w_next = ST_EXEC;
        end else begin
          w_ctrl.illegal = 1'b1;
          w_next         = ST_FETCH;
        end
      end

      ST_EXEC: begin
        case (i_Opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            w_ctrl.alu_op    = rr_alu_op(i_Opcode);
            w_ctrl.alu_src_b = 1'b0;
            w_next           = ST_WB;
          end
          OP_ADDI: begin
            w_ctrl.alu_op    = ALU_ADD;
            w_ctrl.alu_src_b = 1'b1;
            w_next           = ST_WB;
          end
          OP_LW, OP_SW: begin
            // Effective address = base + imm, latched into the ALU result reg.
            w_ctrl.alu_op    = ALU_ADD;
            w_ctrl.alu_src_b = 1'b1;
            w_next           = ST_MEM;
          end
          OP_BEQ: begin
            w_ctrl.alu_op    = ALU_SUB;
            w_ctrl.alu_src_b = 1'b0;
            if (i_Zero) begin
              w_ctrl.pc_write = 1'b1;
              w_ctrl.pc_sel   = PC_BRANCH;
            end
            w_ctrl.retired = 1'b1;
            w_next         = ST_FETCH;
          end
          OP_JMP: begin
            w_ctrl.pc_write = 1'b1;
            w_ctrl.pc_sel   = PC_JUMP;
            w_ctrl.retired  = 1'b1;
            w_next          = ST_FETCH;
          end
          default: begin
            // Unreachable: DECODE only enters EXEC for the opcodes above.
            w_next = ST_FETCH;
          end
        endcase
      end

      ST_MEM: begin
        w_ctrl.mem_req  = 1'b1;
        w_ctrl.addr_sel = 1'b1;
        w_ctrl.mem_we   = (i_Opcode == OP_SW);
        if (i_MemAck) begin
          if (i_Opcode == OP_SW) begin
            w_ctrl.retired = 1'b1;
            w_next         = ST_FETCH;
          end else begin
            w_next = ST_WB;
          end
        end else if (w_expired) begin
          w_set_fault = 1'b1;
          w_next      = ST_HALT;
        end
      end

      ST_WB: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.wb_sel    = (i_Opcode == OP_LW);
        w_ctrl.retired   = 1'b1;
        w_next           = ST_FETCH;
      end

      ST_HALT: begin
        w_ctrl.halted = 1'b1;
      end

      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Sticky watchdog fault; only reset clears it.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_fault <= 1'b0;
    end else if (w_set_fault) begin
      r_fault <= 1'b1;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_count <= '0;
    end else if (w_ctrl.retired) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_MemReq     = w_ctrl.mem_req;
  assign o_MemWe      = w_ctrl.mem_we;
  assign o_AddrSel    = w_ctrl.addr_sel;
  assign o_IrWrite    = w_ctrl.ir_write;
  assign o_PcWrite    = w_ctrl.pc_write;
  assign o_PcSel      = w_ctrl.pc_sel;
  assign o_AluOp      = w_ctrl.alu_op;
  assign o_AluSrcB    = w_ctrl.alu_src_b;
  assign o_RegWrite   = w_ctrl.reg_write;
  assign o_WbSel      = w_ctrl.wb_sel;
  assign o_Retired    = w_ctrl.retired;
  assign o_Illegal    = w_ctrl.illegal;
  assign o_Halted     = w_ctrl.halted;
  assign o_InstrCount = r_count;
  assign o_Fault      = r_fault;
  assign o_State      = r_state;

endmodule

// File: tb/tb_pqp_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_pqp_control_fsm
// Directed bench for the PQP control FSM. Inputs change 2 time units after
// the rising edge and outputs are checked 1 unit later, well clear of the
// edge. Expected values are hand-derived from the instruction cycle table.
// -----------------------------------------------------------------------------
module tb_pqp_control_fsm;
  import pqp_control_fsm_pkg::*;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 15;

  logic             i_Clk = 1'b0;
  logic             i_Rst;
  logic [3:0]       i_Opcode;
  logic             i_Zero;
  logic             i_MemAck;
  logic             o_MemReq;
  logic             o_MemWe;
  logic             o_AddrSel;
  logic             o_IrWrite;
  logic             o_PcWrite;
  logic [1:0]       o_PcSel;
  logic [2:0]       o_AluOp;
  logic             o_AluSrcB;
  logic             o_RegWrite;
  logic             o_WbSel;
  logic             o_Retired;
  logic [CNT_W-1:0] o_InstrCount;
  logic             o_Illegal;
  logic             o_Halted;
  logic             o_Fault;
  logic [2:0]       o_State;

  pqp_control_fsm #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .i_Clk        (i_Clk),
    .i_Rst        (i_Rst),
    .i_Opcode     (i_Opcode),
    .i_Zero       (i_Zero),
    .i_MemAck     (i_MemAck),
    .o_MemReq     (o_MemReq),
    .o_MemWe      (o_MemWe),
    .o_AddrSel    (o_AddrSel),
    .o_IrWrite    (o_IrWrite),
    .o_PcWrite    (o_PcWrite),
    .o_PcSel      (o_PcSel),
    .o_AluOp      (o_AluOp),
    .o_AluSrcB    (o_AluSrcB),
    .o_RegWrite   (o_RegWrite),
    .o_WbSel      (o_WbSel),
    .o_Retired    (o_Retired),
    .o_InstrCount (o_InstrCount),
    .o_Illegal    (o_Illegal),
    .o_Halted     (o_Halted),
    .o_Fault      (o_Fault),
    .o_State      (o_State)
  );

  // clock
  always #5 i_Clk = ~i_Clk;

  int total = 0;
  int bad   = 0;
  int errs;
  int req_cycles;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 2 units past the next rising edge.
  task automatic cyc();
    @(posedge i_Clk);
    #2;
  endtask

  // Current cycle is FETCH; ack it with the given opcode and step to DECODE.
  task automatic fetch(input logic [3:0] op);
    i_MemAck = 1'b1;
    i_Opcode = op;
    #1;
    chk("fetch_state", o_State, ST_FETCH);
    chk("fetch_memreq", o_MemReq, 1);
    chk("fetch_addrsel", o_AddrSel, 0);
    chk("fetch_irwrite", o_IrWrite, 1);
    chk("fetch_pcwrite", o_PcWrite, 1);
    chk("fetch_pcsel", o_PcSel, PC_INC);
    cyc();
    #1;
    chk("decode_state", o_State, ST_DECODE);
  endtask

  initial begin
    i_Rst    = 1'b1;
    i_Opcode = 4'h0;
    i_Zero   = 1'b0;
    i_MemAck = 1'b0;

    // ---------------- reset ----------------
    repeat (3) cyc();
    #1;
    chk("rst_state", o_State, ST_IDLE);
    chk("rst_memreq", o_MemReq, 0);
    chk("rst_count", o_InstrCount, 0);
    chk("rst_fault", o_Fault, 0);
    chk("rst_halted", o_Halted, 0);
    i_Rst = 1'b0;
    i_MemAck = 1'b1;
    #1;
    chk("idle_state", o_State, ST_IDLE);
    chk("idle_memreq", o_MemReq, 0);
    cyc();

    // ---------------- ADD, ack always 1 ----------------
    fetch(OP_ADD);
    chk("add_dec_retired", o_Retired, 0);
    cyc(); #1;
    chk("add_exec_state", o_State, ST_EXEC);
    chk("add_exec_aluop", o_AluOp, ALU_ADD);
    chk("add_exec_srcb", o_AluSrcB, 0);
    cyc(); #1;
    chk("add_wb_state", o_State, ST_WB);
    chk("add_wb_regwrite", o_RegWrite, 1);
    chk("add_wb_wbsel", o_WbSel, 0);
    chk("add_wb_retired", o_Retired, 1);
    chk("add_wb_count", o_InstrCount, 0);
    cyc(); #1;
    chk("add_next_state", o_State, ST_FETCH);
    chk("add_count", o_InstrCount, 1);

    // ---------------- LW, ack 3 cycles late in MEM ----------------
    fetch(OP_LW);
    cyc();
    i_MemAck = 1'b0;
    #1;
    chk("lw_exec_state", o_State, ST_EXEC);
    chk("lw_exec_srcb", o_AluSrcB, 1);
    chk("lw_exec_aluop", o_AluOp, ALU_ADD);
    req_cycles = 0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      i_MemAck = (k == 3);
      #1;
      chk("lw_mem_state", o_State, ST_MEM);
      chk("lw_mem_addrsel", o_AddrSel, 1);
      chk("lw_mem_we", o_MemWe, 0);
      if (o_MemReq) req_cycles++;
    end
    chk("lw_memreq_cycles", req_cycles, 4);
    cyc(); #1;
    chk("lw_wb_state", o_State, ST_WB);
    chk("lw_wb_wbsel", o_WbSel, 1);
    chk("lw_wb_regwrite", o_RegWrite, 1);
    chk("lw_wb_retired", o_Retired, 1);
    cyc(); #1;
    chk("lw_count", o_InstrCount, 2);

    // ---------------- BEQ taken ----------------
    fetch(OP_BEQ);
    cyc();
    i_Zero = 1'b1;
    #1;
    chk("beq1_state", o_State, ST_EXEC);
    chk("beq1_aluop", o_AluOp, ALU_SUB);
    chk("beq1_pcwrite", o_PcWrite, 1);
    chk("beq1_pcsel", o_PcSel, PC_BRANCH);
    chk("beq1_retired", o_Retired, 1);
    cyc(); #1;
    chk("beq1_next", o_State, ST_FETCH);
    chk("beq1_count", o_InstrCount, 3);

    // ---------------- BEQ not taken ----------------
    fetch(OP_BEQ);
    cyc();
    i_Zero = 1'b0;
    #1;
    chk("beq0_pcwrite", o_PcWrite, 0);
    chk("beq0_retired", o_Retired, 1);
    cyc(); #1;
    chk("beq0_count", o_InstrCount, 4);

    // ---------------- JMP ----------------
    fetch(OP_JMP);
    cyc(); #1;
    chk("jmp_pcwrite", o_PcWrite, 1);
    chk("jmp_pcsel", o_PcSel, PC_JUMP);
    chk("jmp_retired", o_Retired, 1);
    cyc(); #1;
    chk("jmp_count", o_InstrCount, 5);

    // ---------------- undefined opcode 0xA ----------------
    fetch(4'hA);
    chk("ill_pulse", o_Illegal, 1);
    chk("ill_retired", o_Retired, 0);
    cyc(); #1;
    chk("ill_next", o_State, ST_FETCH);
    chk("ill_pulse_gone", o_Illegal, 0);
    chk("ill_count", o_InstrCount, 5);

    // ---------------- NOP ----------------
    fetch(OP_NOP);
    chk("nop_retired", o_Retired, 1);
    cyc(); #1;
    chk("nop_next", o_State, ST_FETCH);
    chk("nop_count", o_InstrCount, 6);

    // ---------------- SW, same-cycle ack ----------------
    fetch(OP_SW);
    cyc(); #1;
    chk("sw_exec_srcb", o_AluSrcB, 1);
    cyc(); #1;
    chk("sw_mem_state", o_State, ST_MEM);
    chk("sw_mem_we", o_MemWe, 1);
    chk("sw_mem_addrsel", o_AddrSel, 1);
    chk("sw_mem_retired", o_Retired, 1);
    cyc(); #1;
    chk("sw_next", o_State, ST_FETCH);
    chk("sw_count", o_InstrCount, 7);

    // ---------------- SUB / AND / OR ALU codes ----------------
    fetch(OP_SUB);
    cyc(); #1;
    chk("sub_aluop", o_AluOp, ALU_SUB);
    cyc(); cyc(); #1;
    fetch(OP_AND);
    cyc(); #1;
    chk("and_aluop", o_AluOp, ALU_AND);
    cyc(); cyc(); #1;
    fetch(OP_OR);
    cyc(); #1;
    chk("or_aluop", o_AluOp, ALU_OR);
    cyc(); cyc(); #1;
    chk("rr_count", o_InstrCount, 10);

    // ---------------- ADDI ----------------
    fetch(OP_ADDI);
    cyc(); #1;
    chk("addi_srcb", o_AluSrcB, 1);
    cyc(); #1;
    chk("addi_wb_state", o_State, ST_WB);
    chk("addi_wb_wbsel", o_WbSel, 0);
    cyc(); #1;
    chk("addi_count", o_InstrCount, 11);

    // ---------------- watchdog: ack on cycle 16 -> no fault ----------------
    i_Opcode = OP_NOP;
    errs = 0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      i_MemAck = 1'b0;
      #1;
      if (o_State !== ST_FETCH || o_Fault !== 1'b0 || o_MemReq !== 1'b1) errs++;
      cyc();
    end
    chk("wd_wait_ok", errs, 0);
    i_MemAck = 1'b1;
    #1;
    chk("wd_late_ack_ir", o_IrWrite, 1);
    cyc(); #1;
    chk("wd_late_ack_state", o_State, ST_DECODE);
    chk("wd_late_ack_fault", o_Fault, 0);
    cyc(); #1;
    chk("wd_late_ack_count", o_InstrCount, 12);

    // ---------------- watchdog: no ack -> fault, HALT ----------------
    errs = 0;
    for (int k = 1; k <= TIMEOUT + 1; k++) begin
      i_MemAck = 1'b0;
      #1;
      if (o_State !== ST_FETCH || o_Fault !== 1'b0 || o_IrWrite !== 1'b0) errs++;
      cyc();
    end
    chk("wd_pending_ok", errs, 0);
    #1;
    chk("wd_halt_state", o_State, ST_HALT);
    chk("wd_fault", o_Fault, 1);
    chk("wd_halted", o_Halted, 1);
    chk("wd_halt_memreq", o_MemReq, 0);
    chk("wd_halt_count", o_InstrCount, 12);

    // ---------------- async reset out of HALT ----------------
    i_Rst = 1'b1;
    #1;
    chk("rst2_state", o_State, ST_IDLE);
    chk("rst2_fault", o_Fault, 0);
    chk("rst2_count", o_InstrCount, 0);
    chk("rst2_halted", o_Halted, 0);
    cyc();
    i_Rst = 1'b0;
    cyc();

    // ---------------- HLT holds ----------------
    fetch(OP_HLT);
    chk("hlt_retired", o_Retired, 1);
    errs = 0;
    for (int k = 0; k < 22; k++) begin
      cyc();
      #1;
      if (o_State !== ST_HALT || o_Halted !== 1'b1 || o_MemReq !== 1'b0) errs++;
    end
    chk("hlt_hold_ok", errs, 0);
    chk("hlt_count", o_InstrCount, 1);

    // ---------------- reset in the middle of SW's MEM ----------------
    i_Rst = 1'b1;
    cyc();
    i_Rst = 1'b0;
    cyc();
    fetch(OP_NOP);
    cyc();
    fetch(OP_SW);
    cyc();
    i_MemAck = 1'b0;
    cyc(); #1;
    chk("swr_mem_state", o_State, ST_MEM);
    chk("swr_memreq", o_MemReq, 1);
    chk("swr_memwe", o_MemWe, 1);
    chk("swr_count_before", o_InstrCount, 1);
    i_Rst = 1'b1;
    #1;
    chk("swr_memreq_drop", o_MemReq, 0);
    chk("swr_memwe_drop", o_MemWe, 0);
    chk("swr_state", o_State, ST_IDLE);
    chk("swr_count", o_InstrCount, 0);
    chk("swr_fault", o_Fault, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
